// File: rtl/hour_counter_pkg.sv
// Shared definitions for the clock stages: hour width, 7-segment codes and
// the legal-modulus check for the hours stage.
package hour_counter_pkg;

    localparam int HOUR_W = 5;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b100_0000;
    localparam logic [6:0] SEG_1     = 7'b111_1001;
    localparam logic [6:0] SEG_2     = 7'b010_0100;
    localparam logic [6:0] SEG_3     = 7'b011_0000;
    localparam logic [6:0] SEG_4     = 7'b001_1001;
    localparam logic [6:0] SEG_5     = 7'b001_0010;
    localparam logic [6:0] SEG_6     = 7'b000_0010;
    localparam logic [6:0] SEG_7     = 7'b111_1000;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b001_0000;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    function automatic logic max_hour_legal(input int m);
        return (m == 12) || (m == 24);
    endfunction

endpackage

// File: rtl/hour_counter_btn_sync_edge.sv
// Synchronizes an active-low, asynchronous button and emits a one-cycle pulse
// on its synchronized press (1 -> 0) edge. Shared by all clock stages.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic fall_evt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_n};
        last_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to the released level so coming out of reset never fakes a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            last_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

    assign fall_evt = last_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/hour_counter_seg7.sv
// BCD digit to active-low 7-segment decoder with blanking enable.
module seg7_decoder
    import hour_counter_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       enable,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (enable) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/hour_counter.sv
// Hours stage of the digital clock: counts minute carries, applies manual
// up/down adjust, flags the day wrap and drives the two hour digits.
module hour_counter
    import hour_counter_pkg::*;
#(
    parameter int MAX_HOUR    = 24,
    parameter int SYNC_STAGES = 2,
    parameter int RESET_HOUR  = 0
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              control1,
    input  logic              control0,
    input  logic              equal60_min,
    input  logic              disable_hour,
    output logic              equal24_hour,
    output logic [HOUR_W-1:0] hour_bin,
    output logic [6:0]        led2,
    output logic [6:0]        led1
);

    localparam logic signed [5:0]  MAX_S   = 6'(MAX_HOUR);
    localparam logic [HOUR_W-1:0]  MAX_U   = HOUR_W'(MAX_HOUR);
    localparam logic [HOUR_W-1:0]  RESET_U = HOUR_W'(RESET_HOUR);

    generate
        if (!max_hour_legal(MAX_HOUR)) begin : g_bad_max_hour
            $error("hour_counter: MAX_HOUR must be 12 or 24");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("hour_counter: SYNC_STAGES must be >= 2");
        end
        if (RESET_HOUR < 0 || RESET_HOUR >= MAX_HOUR) begin : g_bad_reset
            $error("hour_counter: RESET_HOUR out of range");
        end
    endgenerate

    logic                adj_evt;
    logic                car_evt;
    logic                equal60_q, equal60_d;
    logic [HOUR_W-1:0]   hour_q, hour_d;
    logic                wrap_q, wrap_d;
    logic signed [5:0]   delta;
    logic signed [5:0]   sum;
    logic signed [5:0]   wrapped;

    btn_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_adj_sync (
        .clk     (clk50),
        .rst_n   (reset),
        .btn_n   (control1),
        .fall_evt(adj_evt)
    );

    // The edge flop tracks the carry even while disabled, so a masked edge is
    // consumed rather than replayed when disable_hour drops.
    assign car_evt = equal60_min & ~equal60_q & ~disable_hour;

    always_comb begin
        equal60_d = equal60_min;
        delta     = 6'sd0;
        if (adj_evt) begin
            delta = control0 ? 6'sd1 : -6'sd1;
        end
        if (car_evt) begin
            delta = delta + 6'sd1;
        end
        sum     = $signed({1'b0, hour_q}) + delta;
        wrapped = sum;
        if (sum < 6'sd0) begin
            wrapped = sum + MAX_S;
        end else if (sum >= MAX_S) begin
            wrapped = sum - MAX_S;
        end
        hour_d = hour_q;
        wrap_d = 1'b0;
        if (adj_evt || car_evt) begin
            if (hour_q >= MAX_U) begin
                hour_d = '0;
            end else begin
                hour_d = HOUR_W'(wrapped);
                wrap_d = car_evt && (sum >= MAX_S);
            end
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            hour_q    <= RESET_U;
            wrap_q    <= 1'b0;
            equal60_q <= 1'b0;
        end else begin
            hour_q    <= hour_d;
            wrap_q    <= wrap_d;
            equal60_q <= equal60_d;
        end
    end

    assign hour_bin     = hour_q;
    assign equal24_hour = wrap_q;

    logic [3:0] digit [2];
    logic [6:0] seg   [2];

    assign digit[0] = 4'(hour_q % 5'd10);
    assign digit[1] = 4'(hour_q / 5'd10);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_digit
            seg7_decoder u_dec (
                .digit (digit[gi]),
                .enable(1'b1),
                .seg   (seg[gi])
            );
        end
    endgenerate

    assign led1 = seg[0];
    assign led2 = seg[1];

endmodule

// File: tb/tb_hour_counter.sv
// Scoreboard bench for hour_counter: stimulus queues expected hour updates,
// per-DUT monitors pop and compare whenever an output changes or pulses.
module tb_hour_counter;

    localparam int SYNC = 2;

    typedef struct {
        int hour;
        bit pulse;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic control1 = 1'b1;
    logic control0 = 1'b1;
    logic eq60_a = 1'b0;
    logic eq60_b = 1'b0;
    logic dis_a = 1'b0;

    logic       wrap_a, wrap_b;
    logic [4:0] hour_a, hour_b;
    logic [6:0] led2_a, led1_a, led2_b, led1_b;

    int total = 0;
    int bad = 0;
    int model_a = 0;
    int model_b = 0;
    int pulses_a = 0;
    int last_a = 0;
    int last_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #10 clk = ~clk;

    hour_counter #(.MAX_HOUR(24), .SYNC_STAGES(SYNC), .RESET_HOUR(0)) dut24 (
        .clk50(clk), .reset(reset), .control1(control1), .control0(control0),
        .equal60_min(eq60_a), .disable_hour(dis_a), .equal24_hour(wrap_a),
        .hour_bin(hour_a), .led2(led2_a), .led1(led1_a)
    );

    hour_counter #(.MAX_HOUR(12), .SYNC_STAGES(SYNC), .RESET_HOUR(0)) dut12 (
        .clk50(clk), .reset(reset), .control1(1'b1), .control0(1'b1),
        .equal60_min(eq60_b), .disable_hour(1'b0), .equal24_hour(wrap_b),
        .hour_bin(hour_b), .led2(led2_b), .led1(led1_b)
    );

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7f;
        endcase
    endfunction

    always @(negedge clk) begin
        if (int'(hour_a) != last_a || wrap_a) begin
            total++;
            if (wrap_a) pulses_a++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL unexpected24: hour=%0d pulse=%0b, no update expected", hour_a, wrap_a);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                if (int'(hour_a) != e.hour || wrap_a != e.pulse ||
                    led2_a != seg_ref(e.hour / 10) || led1_a != seg_ref(e.hour % 10)) begin
                    bad++;
                    $display("FAIL update24: got hour=%0d pulse=%0b led2=%h led1=%h, want hour=%0d pulse=%0b led2=%h led1=%h",
                             hour_a, wrap_a, led2_a, led1_a, e.hour, e.pulse,
                             seg_ref(e.hour / 10), seg_ref(e.hour % 10));
                end else begin
                    $display("update24 ok: hour=%0d pulse=%0b", hour_a, wrap_a);
                end
            end
        end
        last_a = int'(hour_a);
    end

    always @(negedge clk) begin
        if (int'(hour_b) != last_b || wrap_b) begin
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL unexpected12: hour=%0d pulse=%0b, no update expected", hour_b, wrap_b);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                if (int'(hour_b) != e.hour || wrap_b != e.pulse ||
                    led2_b != seg_ref(e.hour / 10) || led1_b != seg_ref(e.hour % 10)) begin
                    bad++;
                    $display("FAIL update12: got hour=%0d pulse=%0b led2=%h led1=%h, want hour=%0d pulse=%0b",
                             hour_b, wrap_b, led2_b, led1_b, e.hour, e.pulse);
                end else begin
                    $display("update12 ok: hour=%0d pulse=%0b", hour_b, wrap_b);
                end
            end
        end
        last_b = int'(hour_b);
    end

    task automatic push_a(input int h, input bit p);
        exp_t e;
        e.hour = h;
        e.pulse = p;
        q_a.push_back(e);
        model_a = h;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic carry_a();
        push_a((model_a + 1) % 24, model_a == 23);
        cycles(1);
        eq60_a = 1'b1;
        cycles(1);
        eq60_a = 1'b0;
        cycles(1);
    endtask

    task automatic carry_b();
        exp_t e;
        e.hour = (model_b + 1) % 12;
        e.pulse = (model_b == 11);
        q_b.push_back(e);
        model_b = e.hour;
        cycles(1);
        eq60_b = 1'b1;
        cycles(1);
        eq60_b = 1'b0;
        cycles(1);
    endtask

    task automatic press_a(input bit dir, input int exp_h);
        push_a(exp_h, 1'b0);
        control0 = dir;
        control1 = 1'b0;
        cycles(SYNC + 3);
        control1 = 1'b1;
        cycles(SYNC + 3);
    endtask

    // Time the carry edge to land in the same cycle as the adjust event.
    task automatic press_with_carry(input bit dir);
        control0 = dir;
        cycles(1);
        control1 = 1'b0;
        repeat (SYNC) @(posedge clk);
        #1;
        eq60_a = 1'b1;
        cycles(1);
        eq60_a = 1'b0;
        cycles(3);
        control1 = 1'b1;
        cycles(SYNC + 3);
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            cycles(1);
            n++;
        end
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d/%0d expected updates never seen", q_a.size(), q_b.size());
        end
    endtask

    task automatic steady_a(input string name, input int exp_h);
        drain();
        total++;
        if (int'(hour_a) != exp_h || wrap_a != 1'b0) begin
            bad++;
            $display("FAIL %s: hour=%0d pulse=%0b, want hour=%0d pulse=0", name, hour_a, wrap_a, exp_h);
        end else begin
            $display("%s ok: hour=%0d", name, hour_a);
        end
    endtask

    initial begin
        int lat;
        int p0;
        #1 reset = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(2);
        steady_a("reset_state", 0);

        // Reset asserted mid-count at 13 must clear without a clock edge
        repeat (13) carry_a();
        drain();
        #3;
        push_a(0, 1'b0);
        reset = 1'b0;
        #1;
        total++;
        if (hour_a != 5'd0 || led2_a != seg_ref(0) || led1_a != seg_ref(0)) begin
            bad++;
            $display("FAIL async_reset: hour=%0d led2=%h led1=%h, want 0 with 00", hour_a, led2_a, led1_a);
        end else begin
            $display("async_reset ok: hour=%0d", hour_a);
        end
        cycles(2);
        #4 reset = 1'b1;
        cycles(2);
        drain();

        repeat (20) carry_a();
        drain();
        p0 = pulses_a;
        repeat (8) carry_a();
        drain();
        total++;
        if (pulses_a - p0 != 1 || model_a != 4) begin
            bad++;
            $display("FAIL day_wrap_count: pulses=%0d, want 1", pulses_a - p0);
        end else begin
            $display("day_wrap_count ok: pulses=%0d", pulses_a - p0);
        end
        repeat (20) carry_a();
        drain();

        // Down press at 0: latency and wrap to 23 without a day pulse
        push_a(23, 1'b0);
        control0 = 1'b0;
        control1 = 1'b0;
        lat = 0;
        while (hour_a != 5'd23 && lat < 20) begin
            cycles(1);
            lat++;
        end
        total++;
        if (lat != SYNC + 1) begin
            bad++;
            $display("FAIL adj_latency: cycles=%0d, want %0d", lat, SYNC + 1);
        end else begin
            $display("adj_latency ok: cycles=%0d", lat);
        end
        cycles(1000);
        steady_a("hold_button", 23);
        control1 = 1'b1;
        cycles(10);
        steady_a("release_button", 23);

        press_a(1'b1, 0);
        press_a(1'b0, 23);
        press_a(1'b0, 22);
        steady_a("adjust_walk", 22);

        push_a(0, 1'b1);
        press_with_carry(1'b1);
        steady_a("carry_plus_up", 0);

        repeat (5) carry_a();
        press_with_carry(1'b0);
        steady_a("carry_plus_down", 5);

        repeat (2) carry_a();
        dis_a = 1'b1;
        cycles(1);
        eq60_a = 1'b1;
        cycles(5);
        steady_a("disabled_edge", 7);
        dis_a = 1'b0;
        cycles(5);
        steady_a("disable_release_high", 7);
        eq60_a = 1'b0;
        cycles(2);
        carry_a();
        steady_a("next_edge", 8);

        repeat (12) carry_b();
        drain();
        total++;
        if (hour_b != 5'd0 || led2_b != seg_ref(0) || led1_b != seg_ref(0)) begin
            bad++;
            $display("FAIL wrap12: hour=%0d led2=%h led1=%h, want 0 with 00", hour_b, led2_b, led1_b);
        end else begin
            $display("wrap12 ok: hour=%0d", hour_b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
